// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Purpose  : Write-back queue merging ALU and load results onto one register-
//            file write port, with ordered buffering and read bypass.
// Revision : 1.0
// ============================================================================
module wb_queue #(
   parameter int WORD  = 64,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid,
   input  logic [4:0]              alu_reg,
   input  logic [WORD-1:0]         alu_data,
   input  logic                    ld_valid,
   input  logic [4:0]              ld_reg,
   input  logic [WORD-1:0]         ld_data,
   output logic                    RegWrite,
   output logic [4:0]              w_reg,
   output logic [WORD-1:0]         w_data,
   output logic                    wb_stall,
   output logic                    overflow,
   output logic [$clog2(DEPTH):0]  q_count,
   input  logic [4:0]              fwd_reg1,
   input  logic [4:0]              fwd_reg2,
   output logic                    fwd_hit1,
   output logic [WORD-1:0]         fwd_data1,
   output logic                    fwd_hit2,
   output logic [WORD-1:0]         fwd_data2
);

   localparam int         C_AW  = $clog2(DEPTH);
   localparam int         C_CW  = C_AW + 1;
   localparam int         C_FW  = C_CW + 1;
   localparam logic [4:0] C_XZR = 5'd31;

   logic [4:0]      ent_reg_q  [DEPTH];
   logic [WORD-1:0] ent_data_q [DEPTH];
   logic [C_AW-1:0] head_q, head_d, tail_q, tail_d, tail_p1;
   logic [C_CW-1:0] count_q, count_d;
   logic            out_v_q, out_v_d, ovf_q, ovf_d;
   logic [4:0]      out_reg_q, out_reg_d;
   logic [WORD-1:0] out_data_q, out_data_d;

   logic            ld_acc, alu_acc, both, pop;
   logic            c0_v, c1_v, push0, push1, drop;
   logic [4:0]      first_reg, c0_reg;
   logic [WORD-1:0] first_data, c0_data;
   logic [C_FW-1:0] free;

   always_comb begin
      ld_acc     = ld_valid && (ld_reg != C_XZR);
      alu_acc    = alu_valid && (alu_reg != C_XZR);
      both       = ld_acc && alu_acc;
      pop        = (count_q != '0);
      first_reg  = ld_acc ? ld_reg : alu_reg;
      first_data = ld_acc ? ld_data : alu_data;

      out_v_d    = 1'b0;
      out_reg_d  = '0;
      out_data_d = '0;
      if (pop) begin
         out_v_d    = 1'b1;
         out_reg_d  = ent_reg_q[head_q];
         out_data_d = ent_data_q[head_q];
      end else if (ld_acc || alu_acc) begin
         out_v_d    = 1'b1;
         out_reg_d  = first_reg;
         out_data_d = first_data;
      end

      // Whatever the output register did not take goes to the tail, oldest first.
      c0_v    = pop ? (ld_acc || alu_acc) : both;
      c0_reg  = pop ? first_reg : alu_reg;
      c0_data = pop ? first_data : alu_data;
      c1_v    = pop && both;

      free    = C_FW'(DEPTH) - {1'b0, count_q} + C_FW'(pop);
      push0   = c0_v && (free >= C_FW'(1));
      push1   = c1_v && (free >= C_FW'(2));
      drop    = (c0_v && !push0) || (c1_v && !push1);

      tail_p1 = tail_q + C_AW'(1);
      head_d  = head_q + C_AW'(pop);
      tail_d  = tail_q + C_AW'(push0) + C_AW'(push1);
      count_d = count_q + C_CW'(push0) + C_CW'(push1) - C_CW'(pop);
      ovf_d   = ovf_q | drop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         out_v_q    <= 1'b0;
         out_reg_q  <= '0;
         out_data_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         out_v_q    <= out_v_d;
         out_reg_q  <= out_reg_d;
         out_data_q <= out_data_d;
         ovf_q      <= ovf_d;
      end
   end

   // Entry storage needs no reset: validity is carried by count_q alone.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (push0) begin
            ent_reg_q[tail_q]  <= c0_reg;
            ent_data_q[tail_q] <= c0_data;
         end
         if (push1) begin
            ent_reg_q[tail_p1]  <= alu_reg;
            ent_data_q[tail_p1] <= alu_data;
         end
      end
   end

   // Search oldest to youngest so the last match is the youngest writer.
   always_comb begin
      logic [C_AW-1:0] idx;
      idx       = '0;
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      if (out_v_q && (out_reg_q == fwd_reg1) && (fwd_reg1 != C_XZR)) begin
         fwd_hit1  = 1'b1;
         fwd_data1 = out_data_q;
      end
      if (out_v_q && (out_reg_q == fwd_reg2) && (fwd_reg2 != C_XZR)) begin
         fwd_hit2  = 1'b1;
         fwd_data2 = out_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + C_AW'(i);
         if (C_CW'(i) < count_q) begin
            if ((ent_reg_q[idx] == fwd_reg1) && (fwd_reg1 != C_XZR)) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = ent_data_q[idx];
            end
            if ((ent_reg_q[idx] == fwd_reg2) && (fwd_reg2 != C_XZR)) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = ent_data_q[idx];
            end
         end
      end
   end

   assign RegWrite = out_v_q;
   assign w_reg    = out_reg_q;
   assign w_data   = out_data_q;
   assign q_count  = count_q;
   assign overflow = ovf_q;
   assign wb_stall = (count_q >= C_CW'(DEPTH - 1));

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Purpose  : Vector table, directed corner sequences and a randomized run of
//            wb_queue checked against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_wb_queue;

   localparam int WORD  = 64;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid, ld_valid;
   logic [4:0]      alu_reg, ld_reg, fwd_reg1, fwd_reg2, w_reg;
   logic [WORD-1:0] alu_data, ld_data, w_data, fwd_data1, fwd_data2;
   logic            RegWrite, wb_stall, overflow, fwd_hit1, fwd_hit2;
   logic [CW-1:0]   q_count;

   always #5 clk = ~clk;

   wb_queue #(.WORD(WORD), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
      .RegWrite(RegWrite), .w_reg(w_reg), .w_data(w_data),
      .wb_stall(wb_stall), .overflow(overflow), .q_count(q_count),
      .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
      .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
      .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2)
   );

   typedef struct {
      logic [4:0]      r;
      logic [WORD-1:0] d;
   } wr_t;

   typedef struct {
      logic            lv;
      logic [4:0]      lr;
      logic [WORD-1:0] ld;
      logic            av;
      logic [4:0]      ar;
      logic [WORD-1:0] ad;
      logic [4:0]      f1;
      logic            e_rw;
      logic [4:0]      e_reg;
      logic [WORD-1:0] e_data;
      int              e_cnt;
      logic            e_hit;
      logic [WORD-1:0] e_fd;
   } vec_t;

   wr_t  mq[$];
   wr_t  m_out;
   bit   m_out_v;
   bit   m_ovf;
   int   vectors     = 0;
   int   miscompares = 0;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a pending list, an output slot, and a bounded capacity.
   task automatic model_step();
      wr_t acc[$];
      wr_t e;
      if (rst) begin
         mq.delete();
         m_out_v = 0;
         m_out.r = '0;
         m_out.d = '0;
         m_ovf   = 0;
         return;
      end
      if (ld_valid && ld_reg != 5'd31) begin
         e.r = ld_reg; e.d = ld_data; acc.push_back(e);
      end
      if (alu_valid && alu_reg != 5'd31) begin
         e.r = alu_reg; e.d = alu_data; acc.push_back(e);
      end
      if (mq.size() > 0) begin
         m_out = mq.pop_front(); m_out_v = 1;
      end else if (acc.size() > 0) begin
         m_out = acc.pop_front(); m_out_v = 1;
      end else begin
         m_out_v = 0;
      end
      foreach (acc[k]) begin
         if (mq.size() < DEPTH) mq.push_back(acc[k]);
         else m_ovf = 1;
      end
   endtask

   function automatic void model_fwd(input logic [4:0] r, output logic hit, output logic [WORD-1:0] d);
      hit = 0;
      d   = '0;
      if (r == 5'd31) return;
      if (m_out_v && m_out.r == r) begin hit = 1; d = m_out.d; end
      foreach (mq[k]) if (mq[k].r == r) begin hit = 1; d = mq[k].d; end
   endfunction

   task automatic check_model(input string tag);
      logic            h;
      logic [WORD-1:0] d;
      chk({tag, ".RegWrite"}, RegWrite, m_out_v);
      if (m_out_v) begin
         chk({tag, ".w_reg"}, w_reg, m_out.r);
         chk({tag, ".w_data"}, w_data, m_out.d);
      end
      chk({tag, ".q_count"}, q_count, mq.size());
      chk({tag, ".wb_stall"}, wb_stall, mq.size() >= DEPTH - 1);
      chk({tag, ".overflow"}, overflow, m_ovf);
      model_fwd(fwd_reg1, h, d);
      chk({tag, ".fwd_hit1"}, fwd_hit1, h);
      chk({tag, ".fwd_data1"}, fwd_data1, d);
      model_fwd(fwd_reg2, h, d);
      chk({tag, ".fwd_hit2"}, fwd_hit2, h);
      chk({tag, ".fwd_data2"}, fwd_data2, d);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic idle();
      ld_valid = 0; ld_reg = 0; ld_data = '0;
      alu_valid = 0; alu_reg = 0; alu_data = '0;
   endtask

   task automatic both_valid(input logic [4:0] lr, input logic [4:0] ar, input logic [WORD-1:0] base);
      ld_valid = 1; ld_reg = lr; ld_data = base;
      alu_valid = 1; alu_reg = ar; alu_data = base + 1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1;
      idle();
      cycle(tag);
      rst = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      int              max_cnt;
      bit              stall_seen;
      bit              obey;
      logic [WORD-1:0] seq;

      rst = 1; idle(); fwd_reg1 = 0; fwd_reg2 = 0;
      @(negedge clk);
      cycle("reset");
      chk("reset.RegWrite", RegWrite, 1'b0);
      chk("reset.w_reg", w_reg, 5'd0);
      chk("reset.w_data", w_data, 64'd0);
      chk("reset.q_count", q_count, 0);
      chk("reset.overflow", overflow, 1'b0);
      chk("reset.wb_stall", wb_stall, 1'b0);
      chk("reset.fwd_hit1", fwd_hit1, 1'b0);
      chk("reset.fwd_hit2", fwd_hit2, 1'b0);
      rst = 0;

      tbl[0] = '{1'b0, 5'd0,  64'h0,  1'b1, 5'd5,  64'hAA, 5'd5,  1'b1, 5'd5,  64'hAA, 0, 1'b1, 64'hAA};
      tbl[1] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  5'd5,  1'b0, 5'd0,  64'h0,  0, 1'b0, 64'h0};
      tbl[2] = '{1'b1, 5'd3,  64'h11, 1'b1, 5'd3,  64'h22, 5'd3,  1'b1, 5'd3,  64'h11, 1, 1'b1, 64'h22};
      tbl[3] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  5'd3,  1'b1, 5'd3,  64'h22, 0, 1'b1, 64'h22};
      tbl[4] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  5'd3,  1'b0, 5'd0,  64'h0,  0, 1'b0, 64'h0};
      tbl[5] = '{1'b1, 5'd31, 64'h55, 1'b1, 5'd31, 64'h66, 5'd31, 1'b0, 5'd0,  64'h0,  0, 1'b0, 64'h0};
      tbl[6] = '{1'b1, 5'd31, 64'h55, 1'b1, 5'd12, 64'h34, 5'd12, 1'b1, 5'd12, 64'h34, 0, 1'b1, 64'h34};
      tbl[7] = '{1'b0, 5'd0,  64'h0,  1'b0, 5'd0,  64'h0,  5'd31, 1'b0, 5'd0,  64'h0,  0, 1'b0, 64'h0};

      for (int i = 0; i < 8; i++) begin
         ld_valid = tbl[i].lv; ld_reg = tbl[i].lr; ld_data = tbl[i].ld;
         alu_valid = tbl[i].av; alu_reg = tbl[i].ar; alu_data = tbl[i].ad;
         fwd_reg1 = tbl[i].f1; fwd_reg2 = 5'd0;
         cycle($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.RegWrite", i), RegWrite, tbl[i].e_rw);
         if (tbl[i].e_rw) begin
            chk($sformatf("tbl%0d.w_reg", i), w_reg, tbl[i].e_reg);
            chk($sformatf("tbl%0d.w_data", i), w_data, tbl[i].e_data);
         end
         chk($sformatf("tbl%0d.q_count", i), q_count, tbl[i].e_cnt);
         chk($sformatf("tbl%0d.fwd_hit1", i), fwd_hit1, tbl[i].e_hit);
         chk($sformatf("tbl%0d.fwd_data1", i), fwd_data1, tbl[i].e_fd);
      end
      idle();

      // Saturation: both ports every cycle, stall ignored.
      do_reset("sat.rst");
      max_cnt = 0; stall_seen = 0;
      for (int i = 0; i < 6; i++) begin
         both_valid(5'(1 + 2 * i), 5'(2 + 2 * i), 64'h1000 + 64'(16 * i));
         fwd_reg1 = 5'(2 + 2 * i); fwd_reg2 = 5'(1 + 2 * i);
         cycle($sformatf("sat%0d", i));
         if (int'(q_count) > max_cnt) max_cnt = int'(q_count);
         if (wb_stall) stall_seen = 1;
      end
      chk("sat.max_q_count", max_cnt, DEPTH);
      chk("sat.stall_seen", stall_seen, 1'b1);
      chk("sat.overflow", overflow, 1'b1);
      idle();
      for (int i = 0; i < 6; i++) cycle($sformatf("drain%0d", i));
      chk("drain.overflow_sticky", overflow, 1'b1);

      // Reset with three entries pending.
      do_reset("mid.rst0");
      for (int i = 0; i < 3; i++) begin
         both_valid(5'(4 + 2 * i), 5'(5 + 2 * i), 64'h2000 + 64'(16 * i));
         cycle($sformatf("mid.fill%0d", i));
      end
      chk("mid.q_count_before", q_count, 3);
      fwd_reg1 = 5'd8; fwd_reg2 = 5'd9;
      rst = 1;
      cycle("mid.rst1");
      rst = 0; idle();
      chk("mid.RegWrite", RegWrite, 1'b0);
      chk("mid.q_count", q_count, 0);
      chk("mid.overflow", overflow, 1'b0);
      chk("mid.fwd_hit1", fwd_hit1, 1'b0);
      chk("mid.fwd_hit2", fwd_hit2, 1'b0);
      alu_valid = 1; alu_reg = 5'd9; alu_data = 64'h99;
      cycle("mid.fresh");
      chk("mid.fresh_RegWrite", RegWrite, 1'b1);
      chk("mid.fresh_w_reg", w_reg, 5'd9);
      chk("mid.fresh_w_data", w_data, 64'h99);
      idle();
      cycle("mid.after");
      chk("mid.after_RegWrite", RegWrite, 1'b0);

      // Steady push+pop across many pointer wraps.
      do_reset("wrap.rst");
      both_valid(5'd1, 5'd2, 64'h3000);
      cycle("wrap.pre0");
      both_valid(5'd3, 5'd4, 64'h3010);
      cycle("wrap.pre1");
      ld_valid = 0;
      for (int i = 0; i < 20; i++) begin
         alu_valid = 1; alu_reg = 5'(i % 30); alu_data = 64'h4000 + 64'(i);
         fwd_reg1 = 5'(i % 30); fwd_reg2 = 5'((i + 29) % 30);
         cycle($sformatf("wrap%0d", i));
         chk($sformatf("wrap%0d.q_count_const", i), q_count, 2);
      end
      idle();

      // Randomized run against the model.
      do_reset("rnd.rst");
      seq = 64'h5000;
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         obey = ($urandom_range(0, 3) != 0);
         idle();
         if (!(obey && wb_stall)) begin
            ld_valid  = $urandom_range(0, 1) == 1;
            ld_reg    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
            ld_data   = {$urandom, $urandom};
            alu_valid = $urandom_range(0, 1) == 1;
            alu_reg   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
            alu_data  = seq;
            seq       = seq + 1;
         end
         fwd_reg1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         fwd_reg2 = 5'($urandom_range(0, 7));
         cycle($sformatf("rnd%0d", i));
      end
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter WORD, default 64, data width of every register value.
REQ-002 Parameter DEPTH, default 4, pending-write queue entries (power of two, at least 2).
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset: one clock; reset is synchronous and active-high.
REQ-005 Port alu_valid / alu_reg / alu_data, input, 1 / 5 / WORD, ALU-result write request.
REQ-006 Port ld_valid / ld_reg / ld_data, input, 1 / 5 / WORD, load-return write request.
REQ-007 Port RegWrite / w_reg / w_data, output, 1 / 5 / WORD, register-file write port, all registered.
REQ-008 Port wb_stall, output, 1, upstream must hold new requests.
REQ-009 Port overflow, output, 1, sticky error flag.
REQ-010 Port q_count, output, $clog2(DEPTH)+1, queued entries, not counting the output register.
REQ-011 Port fwd_reg1 / fwd_reg2, input, 5, bypass lookup addresses.
REQ-012 Port fwd_hit1 / fwd_data1 and fwd_hit2 / fwd_data2, output, 1 / WORD, combinational bypass result.

Function
REQ-013 A request with reg == 31 (XZR) shall be discarded: never enqueued, never written, never counted.
REQ-014 When both inputs are valid in one cycle, the ld request is older and is ordered ahead of the alu request.
REQ-015 The output register shall load every cycle. If the queue is non-empty, it takes the head entry (pop). Else, if an accepted request is present this cycle, it takes the oldest one directly. Otherwise RegWrite is 0.
REQ-016 Minimum latency: a request sampled at edge N, with the queue empty, appears on RegWrite/w_reg/w_data after edge N; the register file writes it at edge N+1.
REQ-017 Accepted requests not taken by the output register shall be appended to the queue in age order; push and pop in the same cycle are both performed.
REQ-018 Write order to the register file shall equal acceptance order.
REQ-019 Queue pointers wrap modulo DEPTH.
REQ-020 q_count shall update by pushes minus pops each cycle and never exceed DEPTH.
REQ-021 wb_stall = (q_count >= DEPTH-1), from registered state only, with no input-to-output combinational path.
REQ-022 Requests that find no free entry in a cycle shall be dropped, youngest first.
REQ-023 A drop shall set overflow to 1, and overflow shall hold until reset.
REQ-024 Bypass search covers the valid output register and all valid queue entries.
REQ-025 fwd_hitK = 1 when some searched entry has reg == fwd_regK, and fwd_dataK is the data of the youngest such entry.
REQ-026 On a bypass miss, fwd_dataK = 0; fwd_reg == 31 always misses.
REQ-027 Bypass results shall not include same-cycle incoming requests.

Reset
REQ-028 While rst is 1 at an edge, the following are cleared: RegWrite=0, w_reg=0, w_data=0, q_count=0, overflow=0, all entries invalid, pointers=0.
REQ-029 While rst is 1, all inputs are ignored.
REQ-030 Reset mid-operation shall discard all pending writes without writing them.
REQ-031 After rst, wb_stall=0, fwd_hit1=0 and fwd_hit2=0.

Verification
REQ-032 Empty queue, alu_valid=1 reg=5 data=0xAA at edge N -> RegWrite=1 w_reg=5 w_data=0xAA after N; RegWrite=0 after N+1; q_count stays 0.
REQ-033 Both valid, ld reg=3 data=0x11 and alu reg=3 data=0x22 -> write 3<-0x11 at the first output cycle, then 3<-0x22; fwd_reg1=3 returns 0x22 while the second write is pending.
REQ-034 Requests with reg=31 on both ports -> no RegWrite, q_count=0, no bypass hit.
REQ-035 Both ports valid every cycle with DEPTH=4, ignoring wb_stall -> wb_stall=1 once q_count=3, q_count saturates at 4, overflow=1; accepted writes emerge in order with none duplicated.
REQ-036 rst=1 for one edge with 3 entries queued -> next cycle RegWrite=0, q_count=0, overflow=0, fwd hits 0; a fresh request then completes with 1-cycle latency.
REQ-037 Push and pop for 20 cycles across pointer wrap -> q_count constant and data order preserved.
